stream_upsizer: RTL and testbench
=================================

Name: stream_upsizer

Overview:
Single-clock valid/ready width converter that packs Ratio consecutive narrow beats into one wide output word. It sits directly downstream of cdc_fifo's destination port, where narrow data is delivered into the wide core domain.
- A beat with last_i closes a frame early and emits a partial word with a lane-keep mask.
- An optional idle timeout emits a partial word so data never stalls in the accumulator.

Parameters:
DataWidth, 8, width of one input beat in bits
Ratio, 4, input beats per output word (>=2)
FlushCycles, 16, consecutive idle cycles with a partial word before forced emission; 0 disables timeout

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
data_i  in  DataWidth  input beat
last_i  in  1  beat ends frame
valid_i  in  1  input valid
ready_o  out  1  input ready
data_o  out  DataWidth*Ratio  packed word; lane k = bits [k*DataWidth +: DataWidth]
keep_o  out  Ratio  lane valid mask, contiguous from lane 0
last_o  out  1  word closes a frame
valid_o  out  1  output valid
ready_i  in  1  output ready

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - valid_o=0, data_o=0, keep_o=0, last_o=0.
  - Lane counter cnt=0, accumulator=0, idle counter=0.
  - ready_o=1 after reset.
- Reset mid-fill discards the partial word and any un-accepted output; no flush is emitted.
- Accept and handshake rules:
  - Input accept = valid_i & ready_o.
  - Output accept = valid_o & ready_i.
  - ready_o = !valid_o | ready_i. It is purely registered-state plus ready_i, with no valid_i-to-ready_o path.
  - Once valid_o=1, data_o, keep_o and last_o are held stable until output accept.
- Packing:
  - An accepted beat is written to accumulator lane cnt.
  - If cnt==Ratio-1 or last_i=1, the word completes:
    - Output registers load the accumulator including this beat.
    - keep_o bit k=1 for k<=cnt; unfilled lanes are zero.
    - last_o=last_i.
    - cnt returns to 0 and the accumulator clears.
  - Otherwise cnt increments.
- Latency: valid_o rises the cycle after the completing beat is accepted.
- Throughput: one beat per cycle sustained while ready_i=1.
- Simultaneous events:
  - Output accept in the same cycle as a completing beat: the output reloads and valid_o stays 1.
  - Output accept with no new word: valid_o falls.
- Timeout (FlushCycles>0):
  - The idle counter increments each cycle with cnt!=0 and no input accept. It saturates at FlushCycles.
  - It clears on any input accept and whenever cnt==0.
  - Flush condition: idle==FlushCycles and output slot free (!valid_o | ready_i) and no input accept.
  - On flush: emit the partial word with keep per filled lanes, last_o=0; cnt, accumulator and idle clear.
  - Input accept in the same cycle as the flush condition: the beat wins and no flush occurs.
  - Flush blocked by a busy output: it stays pending (counter saturated) until the slot frees.
- States:
  - EMPTY (cnt==0).
  - FILLING (cnt in 1..Ratio-1).
  - FILLING to EMPTY on completion or flush.
  - EMPTY to FILLING on a non-completing beat.
- A last_i beat in EMPTY emits a single-lane word with keep=...0001.
- Widths:
  - cnt is $clog2(Ratio) bits.
  - The idle counter is $clog2(FlushCycles+1) bits.
  - Ratio must be >=2; elaboration fails otherwise.

Decomposition:
- Shared stream package:
  - localparam function for lane-mask generation (cnt to keep thermometer).
  - Typedef for the {data, keep, last} output bundle, parameterized via struct in the instantiating module.
- Sub-module upsizer_flush_timer: idle counter, saturation and flush request.
  - Inputs: clk, reset, active (cnt!=0), kick (input accept), clear.
  - Output: expired.
- Output stage is in-module; pipe_register is not reused because ready_o depends only on output-slot state.

Test Plan:
All tests use DataWidth=8, Ratio=4, FlushCycles=4.
1. Full word:
   - Stimulus: beats 0x11,0x22,0x33,0x44 back-to-back, ready_i=1.
   - Response: next cycle valid_o=1, data_o=0x44332211, keep_o=4'b1111, last_o=0; ready_o stays 1 throughout.
2. Early last:
   - Stimulus: beats 0xAA, 0xBB with last_i=1 on 0xBB.
   - Response: data_o=0x0000BBAA, keep_o=4'b0011, last_o=1; next frame starts in lane 0.
3. Backpressure:
   - Stimulus: word valid, ready_i=0 for 5 cycles.
   - Response: ready_o=0, outputs stable.
   - Stimulus: raise ready_i with 4 new beats pending.
   - Response: drain and first new beat accepted in the same cycle; second word 0x88776655 correct, no beat lost or duplicated.
4. Timeout:
   - Stimulus: single beat 0x5A accepted in cycle 0, valid_i=0 afterwards.
   - Response: valid_o=1 in cycle 5 with data_o=0x0000005A, keep_o=4'b0001, last_o=0.
   - Stimulus: repeat with a beat in cycle 3.
   - Response: no flush; timer restarts.
5. Reset mid-fill:
   - Stimulus: two beats accepted, then reset for 1 cycle.
   - Response: valid_o=0, no partial emitted; next 4 beats 0x01..0x04 give 0x04030201, keep 4'b1111.
6. Streaming throughput:
   - Stimulus: 12 continuous beats with random ready_i.
   - Response: 3 words, in order, matching a scoreboard.
   - Stimulus: ready_i=1 throughout.
   - Response: ready_o never deasserts.

Source files
------------

// File: rtl/stream_upsizer_pkg.sv
// Shared definitions for the stream upsizer: accumulator fill states and the
// lane-mask helper used to build keep masks.
package stream_upsizer_pkg;

   typedef enum logic {
      ST_EMPTY   = 1'b0,
      ST_FILLING = 1'b1
   } fill_state_e;

   // Upper bound on Ratio supported by lane_mask.
   localparam int unsigned MaxLanes = 32;

   // Thermometer mask with lanes 0..last_lane set.
   function automatic logic [MaxLanes-1:0] lane_mask(input int unsigned last_lane);
      logic [MaxLanes-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < MaxLanes; k++) begin
         if (k <= last_lane) m[k] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/upsizer_flush_timer.sv
// Idle timer for the upsizer: counts cycles a partial word sits untouched and
// raises expired once the count saturates at FlushCycles.
module upsizer_flush_timer #(
   parameter int unsigned FlushCycles = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic active,
   input  logic kick,
   input  logic clear,
   output logic expired
);

   if (FlushCycles == 0) begin : g_off
      assign expired = 1'b0;
   end else begin : g_on
      localparam int unsigned IdleW = $clog2(FlushCycles + 1);
      localparam logic [IdleW-1:0] IdleMax = IdleW'(FlushCycles);

      logic [IdleW-1:0] idle_q;

      // Saturate rather than wrap so a blocked flush stays pending.
      always_ff @(posedge clk) begin
         if (reset) begin
            idle_q <= '0;
         end else if (clear || kick || !active) begin
            idle_q <= '0;
         end else if (idle_q != IdleMax) begin
            idle_q <= idle_q + IdleW'(1);
         end
      end

      assign expired = (idle_q == IdleMax);
   end

endmodule

// File: rtl/stream_upsizer.sv
// Packs Ratio narrow valid/ready beats into one wide word with a lane-keep mask;
// frames may close early on last_i and an idle timeout flushes stalled partials.
module stream_upsizer
   import stream_upsizer_pkg::*;
#(
   parameter int unsigned DataWidth   = 8,
   parameter int unsigned Ratio       = 4,
   parameter int unsigned FlushCycles = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DataWidth-1:0]       data_i,
   input  logic                       last_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic [DataWidth*Ratio-1:0] data_o,
   output logic [Ratio-1:0]           keep_o,
   output logic                       last_o,
   output logic                       valid_o,
   input  logic                       ready_i
);

   localparam int unsigned CntW  = $clog2(Ratio);
   localparam int unsigned WordW = DataWidth * Ratio;
   localparam logic [CntW-1:0] CntMax = CntW'(Ratio - 1);

   if (Ratio < 2 || Ratio > MaxLanes) begin : g_bad_ratio
      $error("stream_upsizer: Ratio must be in 2..%0d", MaxLanes);
   end

   typedef struct packed {
      logic [WordW-1:0] data;
      logic [Ratio-1:0] keep;
      logic             last;
   } word_t;

   fill_state_e         state_q, state_d;
   logic [CntW-1:0]     cnt_q;
   logic [WordW-1:0]    acc_q;
   logic [WordW-1:0]    acc_beat;
   word_t               out_q, out_d;
   logic                valid_q;
   logic                slot_free, in_acc, complete, flush, expired;
   logic [MaxLanes-1:0] mask_full, mask_part;

   // ready_o depends only on the output slot and ready_i, never on valid_i.
   assign slot_free = !valid_q || ready_i;
   assign in_acc    = valid_i && slot_free;
   assign complete  = in_acc && ((cnt_q == CntMax) || last_i);
   assign flush     = expired && slot_free && !in_acc && (state_q == ST_FILLING);

   assign mask_full = lane_mask(32'(cnt_q));
   assign mask_part = lane_mask(32'(cnt_q) - 32'd1);

   always_comb begin
      acc_beat = acc_q;
      acc_beat[cnt_q*DataWidth +: DataWidth] = data_i;
   end

   always_comb begin
      out_d = out_q;
      if (complete) begin
         out_d.data = acc_beat;
         out_d.keep = mask_full[Ratio-1:0];
         out_d.last = last_i;
      end else if (flush) begin
         out_d.data = acc_q;
         out_d.keep = mask_part[Ratio-1:0];
         out_d.last = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY:   if (in_acc && !complete) state_d = ST_FILLING;
         ST_FILLING: if (complete || flush)   state_d = ST_EMPTY;
         default:    state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         cnt_q   <= '0;
         acc_q   <= '0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         if (complete || flush) begin
            cnt_q <= '0;
            acc_q <= '0;
         end else if (in_acc) begin
            cnt_q <= cnt_q + CntW'(1);
            acc_q <= acc_beat;
         end
         // A new word reloads the slot even while the old one drains.
         if (complete || flush) begin
            valid_q <= 1'b1;
         end else if (ready_i) begin
            valid_q <= 1'b0;
         end
         out_q <= out_d;
      end
   end

   upsizer_flush_timer #(
      .FlushCycles(FlushCycles)
   ) u_flush_timer (
      .clk    (clk),
      .reset  (reset),
      .active (state_q == ST_FILLING),
      .kick   (in_acc),
      .clear  (flush),
      .expired(expired)
   );

   assign ready_o = slot_free;
   assign data_o  = out_q.data;
   assign keep_o  = out_q.keep;
   assign last_o  = out_q.last;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (DataWidth=8, Ratio=4, FlushCycles=4):
// directed vector table, corner-case sequences and a queue-based reference model.
module tb_stream_upsizer;

   localparam int DW = 8;
   localparam int R  = 4;
   localparam int FC = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [DW-1:0] data_i = '0;
   logic          last_i = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [DW*R-1:0] data_o;
   logic [R-1:0]  keep_o;
   logic          last_o;
   logic          valid_o;
   logic          ready_i = 1'b1;

   stream_upsizer #(.DataWidth(DW), .Ratio(R), .FlushCycles(FC)) dut (
      .clk(clk), .reset(reset), .data_i(data_i), .last_i(last_i),
      .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .keep_o(keep_o),
      .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: frame beats held in a queue, output slot as plain variables.
   logic [7:0]  m_beats[$];
   int          m_idle;
   bit          m_valid;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   bit          m_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic void m_reset();
      m_beats.delete();
      m_idle = 0; m_valid = 0; m_data = '0; m_keep = '0; m_last = 0;
   endfunction

   function automatic void m_emit(input bit l);
      m_data = '0;
      foreach (m_beats[k]) m_data = m_data | (32'(m_beats[k]) << (8 * k));
      m_keep  = 4'((1 << m_beats.size()) - 1);
      m_last  = l;
      m_valid = 1;
      m_beats.delete();
      m_idle = 0;
   endfunction

   function automatic void m_step(input bit v, input logic [7:0] d, input bit l, input bit r);
      bit rdy;
      rdy = !m_valid || r;
      if (m_valid && r) m_valid = 0;
      if (v && rdy) begin
         m_beats.push_back(d);
         m_idle = 0;
         if (m_beats.size() == R || l) m_emit(l);
      end else if (m_beats.size() != 0) begin
         if (m_idle == FC && rdy) m_emit(0);
         else if (m_idle < FC) m_idle++;
      end else begin
         m_idle = 0;
      end
   endfunction

   task automatic check_out();
      chk("valid_o", valid_o, m_valid);
      if (m_valid) begin
         chk("data_o", data_o, m_data);
         chk("keep_o", keep_o, m_keep);
         chk("last_o", last_o, m_last);
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit r);
      valid_i = v; data_i = d; last_i = l; ready_i = r;
      #1;
      chk("ready_o", ready_o, !m_valid || r);
      @(posedge clk);
      m_step(v, d, l, r);
      #1;
      check_out();
   endtask

   task automatic do_reset();
      reset = 1; valid_i = 0; last_i = 0; data_i = '0; ready_i = 1;
      @(posedge clk);
      m_reset();
      #1;
      reset = 0;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_keep", keep_o, 0);
      chk("rst_last", last_o, 0);
      ready_i = 0;
      #1;
      chk("rst_ready", ready_o, 1);
      ready_i = 1;
   endtask

   typedef struct {
      bit          v;
      logic [7:0]  d;
      bit          l;
      bit          r;
      bit          e_v;
      logic [31:0] e_d;
      logic [3:0]  e_k;
      bit          e_l;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  beats6[12];
      logic [31:0] sb[$];
      logic [31:0] w;
      int          idx, got;
      bit          r, v, acc;

      tbl[0] = '{1, 8'h11, 0, 1, 0, 32'h0,        4'h0, 0};
      tbl[1] = '{1, 8'h22, 0, 1, 0, 32'h0,        4'h0, 0};
      tbl[2] = '{1, 8'h33, 0, 1, 0, 32'h0,        4'h0, 0};
      tbl[3] = '{1, 8'h44, 0, 1, 1, 32'h44332211, 4'hF, 0};
      tbl[4] = '{1, 8'hAA, 0, 1, 0, 32'h0,        4'h0, 0};
      tbl[5] = '{1, 8'hBB, 1, 1, 1, 32'h0000BBAA, 4'h3, 1};
      tbl[6] = '{1, 8'hCC, 1, 1, 1, 32'h000000CC, 4'h1, 1};
      tbl[7] = '{0, 8'h00, 0, 1, 0, 32'h0,        4'h0, 0};

      m_reset();
      do_reset();

      // Full word, early last, single-lane last with simultaneous reload.
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r);
         chk($sformatf("tbl%0d_valid", i), valid_o, tbl[i].e_v);
         if (tbl[i].e_v) begin
            chk($sformatf("tbl%0d_data", i), data_o, tbl[i].e_d);
            chk($sformatf("tbl%0d_keep", i), keep_o, tbl[i].e_k);
            chk($sformatf("tbl%0d_last", i), last_o, tbl[i].e_l);
         end
      end

      // Backpressure: held word, stalled input, then drain with new beats.
      do_reset();
      cycle(1, 8'h11, 0, 1);
      cycle(1, 8'h22, 0, 1);
      cycle(1, 8'h33, 0, 1);
      cycle(1, 8'h44, 0, 1);
      for (int i = 0; i < 5; i++) begin
         cycle(1, 8'h55, 0, 0);
         chk("bp_ready_low", ready_o, 0);
         chk("bp_hold_data", data_o, 32'h44332211);
         chk("bp_hold_valid", valid_o, 1);
      end
      cycle(1, 8'h55, 0, 1);
      cycle(1, 8'h66, 0, 1);
      cycle(1, 8'h77, 0, 1);
      cycle(1, 8'h88, 0, 1);
      chk("bp_word2", data_o, 32'h88776655);
      chk("bp_word2_keep", keep_o, 4'hF);
      cycle(0, 8'h00, 0, 1);

      // Timeout flush after FC idle cycles, then a restart that postpones it.
      do_reset();
      cycle(1, 8'h5A, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 8'h00, 0, 1);
         chk("to_no_early", valid_o, 0);
      end
      cycle(0, 8'h00, 0, 1);
      chk("to_valid", valid_o, 1);
      chk("to_data", data_o, 32'h0000005A);
      chk("to_keep", keep_o, 4'h1);
      chk("to_last", last_o, 0);
      cycle(0, 8'h00, 0, 1);
      chk("to_drained", valid_o, 0);

      cycle(1, 8'h5A, 0, 1);
      cycle(0, 8'h00, 0, 1);
      cycle(0, 8'h00, 0, 1);
      cycle(1, 8'h6B, 0, 1);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 8'h00, 0, 1);
         chk("to2_restart", valid_o, 0);
      end
      cycle(0, 8'h00, 0, 1);
      chk("to2_valid", valid_o, 1);
      chk("to2_data", data_o, 32'h00006B5A);
      chk("to2_keep", keep_o, 4'h3);
      cycle(0, 8'h00, 0, 1);

      // Reset mid-fill discards the partial word.
      do_reset();
      cycle(1, 8'hE1, 0, 1);
      cycle(1, 8'hE2, 0, 1);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cycle(0, 8'h00, 0, 1);
         chk("rmf_no_partial", valid_o, 0);
      end
      cycle(1, 8'h01, 0, 1);
      cycle(1, 8'h02, 0, 1);
      cycle(1, 8'h03, 0, 1);
      cycle(1, 8'h04, 0, 1);
      chk("rmf_data", data_o, 32'h04030201);
      chk("rmf_keep", keep_o, 4'hF);
      cycle(0, 8'h00, 0, 1);

      // Streaming with random output backpressure against a word scoreboard.
      do_reset();
      for (int i = 0; i < 12; i++) beats6[i] = 8'($urandom);
      for (int wd = 0; wd < 3; wd++) begin
         w = {beats6[4*wd+3], beats6[4*wd+2], beats6[4*wd+1], beats6[4*wd]};
         sb.push_back(w);
      end
      idx = 0; got = 0;
      for (int c = 0; c < 200 && (idx < 12 || got < 3); c++) begin
         r = (idx >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
         if (valid_o && r) begin
            if (sb.size() > 0) chk("sb_word", data_o, sb.pop_front());
            else chk("sb_extra_word", 1, 0);
            got++;
         end
         v = (idx < 12);
         acc = v && (!m_valid || r);
         cycle(v, v ? beats6[idx] : 8'h00, 0, r);
         if (acc) idx++;
      end
      chk("sb_beats_accepted", idx, 12);
      chk("sb_word_count", got, 3);

      // Sustained throughput with ready_i held high.
      for (int i = 0; i < 12; i++) begin
         cycle(1, 8'(i + 8'h30), 0, 1);
         chk("tp_ready", ready_o, 1);
      end
      chk("tp_last_word", data_o, 32'h3B3A3938);
      cycle(0, 8'h00, 0, 1);

      // Random traffic with last, idle gaps and backpressure against the model.
      for (int c = 0; c < 400; c++) begin
         cycle(((c % 40) < 30) && ($urandom_range(0, 9) < 7), 8'($urandom),
               $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
